rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/arb_defs.sv | 33 +++
 rtl/Mux2to4.sv | 12 +
 rtl/rr_arbiter4.sv | 91 +++++++++
 tb/tb_rr_arbiter4.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_defs.sv
// Shared arbiter definitions: FSM encodings, default hold limit and a
// rotating round-robin pick helper reused by the arbiter family.
package arb_defs;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int ARB_MAX_HOLD_DEFAULT = 8;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Rotate the request vector so the pointer lands on bit 0, take the
  // lowest set bit, then rotate the answer back by adding the pointer.
  function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] ofs;
    rr_pick_t   res;
    dbl = {req, req};
    rot = dbl[ptr +: 4];
    if (rot[0])      ofs = 2'd0;
    else if (rot[1]) ofs = 2'd1;
    else if (rot[2]) ofs = 2'd2;
    else             ofs = 2'd3;
    res.found = |rot;
    res.idx   = ptr + ofs;
    return res;
  endfunction

endpackage

// File: rtl/Mux2to4.sv
// 2-to-4 one-hot decoder shared across the arbiter family.
module Mux2to4 (
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y      = '0;
    y[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a two-state FSM, one idle cycle between
// owners and forced release of a contended owner after MAX_HOLD cycles.
module rr_arbiter4
  import arb_defs::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  output logic [3:0] Gnt,
  output logic [1:0] GntId,
  output logic       GntValid,
  output logic       Preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic       state_q,   state_d;
  logic [1:0] ptr_q,     ptr_d;
  logic [1:0] gnt_id_q,  gnt_id_d;
  logic [7:0] cnt_q,     cnt_d;
  logic       preempt_q, preempt_d;

  logic [3:0] owner_oh;
  logic [3:0] others;
  rr_pick_t   pick;

  Mux2to4 u_dec (
    .sel (gnt_id_q),
    .y   (owner_oh)
  );

  assign others = Req & ~owner_oh;
  assign pick   = rr_pick(Req, ptr_q);

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (pick.found) begin
        state_d  = ST_GRANT;
        gnt_id_d = pick.idx;
        ptr_d    = pick.idx + 2'd1;
        cnt_d    = '0;
      end
    end else begin
      // Owner release wins over expiry, so Preempt only fires while held.
      if (!Req[gnt_id_q]) begin
        state_d = ST_IDLE;
      end else if (cnt_q == HOLD_LAST) begin
        if (|others) begin
          state_d   = ST_IDLE;
          preempt_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from before the edge, independent of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_id_q  <= '0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign GntValid = (state_q == ST_GRANT);
  assign GntId    = gnt_id_q;
  assign Gnt      = owner_oh & {4{GntValid}};
  assign Preempt  = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus random
// traffic compared against an ownership-level reference model.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       Clk;
  logic       Rst;
  logic [3:0] Req;
  logic [3:0] Gnt;
  logic [1:0] GntId;
  logic       GntValid;
  logic       Preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, where the search starts next,
  // how many grant cycles the owner has had, and the preempt pulse.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_preempt;

  bit       prev_valid;
  bit [1:0] prev_id;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req      (Req),
    .Gnt      (Gnt),
    .GntId    (GntId),
    .GntValid (GntValid),
    .Preempt  (Preempt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, expd, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_hold     = 0;
    m_preempt  = 1'b0;
    prev_valid = 1'b0;
    prev_id    = 2'd0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit others;
    m_preempt = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (m_owner < 0 && r[i]) begin
          m_owner = i;
          m_ptr   = (i + 1) % 4;
          m_hold  = 1;
        end
      end
    end else begin
      others = 1'b0;
      for (int i = 0; i < 4; i++)
        if (i != m_owner && r[i]) others = 1'b1;
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_hold >= MAX_HOLD && others) begin
        m_owner   = -1;
        m_preempt = 1'b1;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt", 32'(Gnt), 32'(eg));
    check("gnt_valid", 32'(GntValid), 32'(m_owner >= 0));
    if (m_owner >= 0) check("gnt_id", 32'(GntId), 32'(m_owner));
    check("preempt", 32'(Preempt), 32'(m_preempt));
    if (GntValid && prev_valid) check("owner_stable", 32'(GntId), 32'(prev_id));
    prev_valid = GntValid;
    prev_id    = GntId;
  endtask

  // Drive Req at the falling edge, update the model on the rising edge and
  // compare at the following falling edge.
  task automatic step(input logic [3:0] r);
    Req = r;
    @(posedge Clk);
    model_step(r);
    @(negedge Clk);
    compare_all();
  endtask

  // Reset asserted between edges must clear the outputs before the next edge.
  task automatic do_reset();
    Rst = 1'b1;
    #1;
    check("rst_async_gnt", 32'(Gnt), 32'h0);
    check("rst_async_valid", 32'(GntValid), 32'h0);
    check("rst_async_preempt", 32'(Preempt), 32'h0);
    check("rst_async_id", 32'(GntId), 32'h0);
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    int q_order[$];
    int expect_order[5] = '{0, 1, 2, 3, 0};
    int hold_cycles;
    int pre_seen;
    logic [3:0] r;

    Rst = 1'b1;
    Req = 4'b0000;
    model_reset();
    repeat (2) @(negedge Clk);
    check("reset_gnt", 32'(Gnt), 32'h0);
    check("reset_valid", 32'(GntValid), 32'h0);
    check("reset_id", 32'(GntId), 32'h0);
    check("reset_preempt", 32'(Preempt), 32'h0);
    Rst = 1'b0;

    // Idle with no requests stays idle.
    repeat (3) step(4'b0000);

    // Single requester 2, then release; pointer now sits at 3.
    step(4'b0100);
    check("single_gnt", 32'(Gnt), 32'h4);
    check("single_id", 32'(GntId), 32'h2);
    repeat (4) step(4'b0100);
    step(4'b0000);
    check("single_release", 32'(Gnt), 32'h0);

    // Wrap: pointer 3 with Req=1001 picks 3, then 0 after release.
    step(4'b1001);
    check("wrap_first", 32'(Gnt), 32'h8);
    step(4'b1001);
    step(4'b0001);
    check("wrap_idle", 32'(GntValid), 32'h0);
    step(4'b0001);
    check("wrap_second", 32'(Gnt), 32'h1);
    step(4'b0000);

    // Fairness: everyone requests, owners drop after two grant cycles.
    do_reset();
    for (int c = 0; c < 60 && q_order.size() < 5; c++) begin
      bit pv;
      r = 4'b1111;
      if (m_owner >= 0 && m_hold >= 2) r[m_owner] = 1'b0;
      pv = GntValid;
      step(r);
      if (GntValid && !pv) q_order.push_back(int'(GntId));
    end
    check("fair_count", 32'(q_order.size()), 32'd5);
    for (int i = 0; i < 5 && i < q_order.size(); i++)
      check($sformatf("fair_order%0d", i), 32'(q_order[i]), 32'(expect_order[i]));
    step(4'b0000);

    // Preemption: 0 holds against 1 for MAX_HOLD cycles, then yields.
    do_reset();
    hold_cycles = 0;
    for (int c = 0; c < MAX_HOLD + 1; c++) begin
      step(4'b0011);
      if (Gnt == 4'b0001) hold_cycles++;
    end
    check("preempt_hold_cycles", 32'(hold_cycles), 32'(MAX_HOLD));
    check("preempt_pulse", 32'(Preempt), 32'h1);
    check("preempt_gnt_zero", 32'(Gnt), 32'h0);
    step(4'b0011);
    check("preempt_next_gnt", 32'(Gnt), 32'h2);
    check("preempt_one_cycle", 32'(Preempt), 32'h0);
    step(4'b0000);

    // No contention: a lone owner keeps the grant past MAX_HOLD.
    hold_cycles = 0;
    pre_seen    = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b0001);
      if (Gnt == 4'b0001) hold_cycles++;
      if (Preempt) pre_seen++;
    end
    check("solo_hold_cycles", 32'(hold_cycles), 32'd20);
    check("solo_no_preempt", 32'(pre_seen), 32'd0);
    step(4'b0000);

    // Reset mid-grant to 3; search restarts at 0 afterwards.
    do_reset();
    step(4'b1000);
    check("midrst_gnt", 32'(Gnt), 32'h8);
    do_reset();
    step(4'b1111);
    check("midrst_first", 32'(Gnt), 32'h1);
    step(4'b0000);

    // Random traffic: sticky requests with occasional flips and resets.
    r = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(9) == 0) r[b] = ~r[b];
      if ($urandom_range(39) == 0) r = 4'b0000;
      if ($urandom_range(299) == 0) do_reset();
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
